// File: rtl/glb_stream_write_if.sv
// Valid/ready stream channel: 17-bit word, [15:0] value, [16] flag bit.
interface glb_stream_write_if;
    logic [16:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glb_stream_write.sv
// GLB-side stream source: up to two 16-bit word buffers sent as length header + payload.
// Optional macro GLB_STREAM_LAST_EN flags the last word of each block in data[16].
module glb_stream_write #(
    parameter int unsigned NUM_BLOCKS = 1,
    parameter int unsigned DEPTH      = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     start,
    input  logic                     cfg_wr_en,
    input  logic                     cfg_wr_blk,
    input  logic [$clog2(DEPTH)-1:0] cfg_wr_addr,
    input  logic [15:0]              cfg_wr_data,
    input  logic [$clog2(DEPTH):0]   cfg_size_0,
    input  logic [$clog2(DEPTH):0]   cfg_size_1,
    glb_stream_write_if.master       strm,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic          HAS_BLK1 = (NUM_BLOCKS > 1);
`ifdef GLB_STREAM_LAST_EN
    localparam logic LAST_EN = 1'b1;
`else
    localparam logic LAST_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [15:0]   mem [0:1][0:DEPTH-1];

    logic [1:0]    state_q, state_d;
    logic          blk_q, blk_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [LW-1:0] len0_q, len0_d;
    logic [LW-1:0] len1_q, len1_d;
    logic [16:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          accept;
    logic          blk_end;
    logic [LW-1:0] cur_len;
    logic [LW-1:0] idx_ext;
    logic [AW-1:0] nxt_idx;
    logic [LW-1:0] clamp0;
    logic [LW-1:0] clamp1;

    // Buffer: not reset, frozen while a run is in progress
    always_ff @(posedge clk) begin
        if (cfg_wr_en && !busy_q) begin
            mem[cfg_wr_blk][cfg_wr_addr] <= cfg_wr_data;
        end
    end

    assign accept  = valid_q && strm.ready;
    assign cur_len = blk_q ? len1_q : len0_q;
    assign idx_ext = LW'(idx_q);
    assign nxt_idx = idx_q + AW'(1);
    assign clamp0  = (cfg_size_0 > DEPTH_L) ? DEPTH_L : cfg_size_0;
    assign clamp1  = (cfg_size_1 > DEPTH_L) ? DEPTH_L : cfg_size_1;

    // Next-state and next-output logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        len0_d  = len0_q;
        len1_d  = len1_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        blk_end = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len0_d  = clamp0;
                    len1_d  = clamp1;
                    blk_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_HDR;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    data_d  = {LAST_EN && (clamp0 == '0), 16'(clamp0)};
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (cur_len != '0) begin
                        state_d = S_PAY;
                        idx_d   = '0;
                        data_d  = {LAST_EN && (cur_len == LW'(1)), mem[blk_q][AW'(0)]};
                    end else begin
                        blk_end = 1'b1;
                    end
                end
            end
            S_PAY: begin
                if (accept) begin
                    if (idx_ext == cur_len - LW'(1)) begin
                        blk_end = 1'b1;
                    end else begin
                        idx_d  = nxt_idx;
                        data_d = {LAST_EN && (idx_ext + LW'(2) == cur_len),
                                  mem[blk_q][nxt_idx]};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Block complete: move to block 1 header or finish the run
        if (blk_end) begin
            idx_d = '0;
            if (HAS_BLK1 && !blk_q) begin
                blk_d   = 1'b1;
                state_d = S_HDR;
                data_d  = {LAST_EN && (len1_q == '0), 16'(len1_q)};
            end else begin
                state_d = S_DONE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                data_d  = '0;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
            blk_d   = 1'b0;
            idx_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            blk_q   <= 1'b0;
            idx_q   <= '0;
            len0_q  <= '0;
            len1_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            len0_q  <= len0_d;
            len1_q  <= len1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign strm.data  = data_q;
    assign strm.valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_glb_stream_write.sv
// Directed bench for glb_stream_write: one NUM_BLOCKS=1 and one NUM_BLOCKS=2 instance.
module tb_glb_stream_write;

`ifdef GLB_STREAM_LAST_EN
    localparam logic LF = 1'b1;
`else
    localparam logic LF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        start_a;
    logic        start_b;
    logic        cfg_wr_en;
    logic        cfg_wr_blk;
    logic [10:0] cfg_wr_addr;
    logic [15:0] cfg_wr_data;
    logic [11:0] cfg_size_0;
    logic [11:0] cfg_size_1;
    logic        busy_a, done_a, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    glb_stream_write_if if_a ();
    glb_stream_write_if if_b ();

    glb_stream_write #(.NUM_BLOCKS(1), .DEPTH(2048)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start_a),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_blk(cfg_wr_blk), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .cfg_size_0(cfg_size_0), .cfg_size_1(cfg_size_1),
        .strm(if_a.master), .busy(busy_a), .done(done_a)
    );

    glb_stream_write #(.NUM_BLOCKS(2), .DEPTH(2048)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start_b),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_blk(cfg_wr_blk), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .cfg_size_0(cfg_size_0), .cfg_size_1(cfg_size_1),
        .strm(if_b.master), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic blk, input logic [10:0] addr, input logic [15:0] val);
        cfg_wr_en   = 1'b1;
        cfg_wr_blk  = blk;
        cfg_wr_addr = addr;
        cfg_wr_data = val;
        step();
        cfg_wr_en   = 1'b0;
    endtask

    // Expected beat j of a 16-word block 0 run
    function automatic logic [16:0] rnd_word(input int j);
        if (j == 0) return 17'd16;
        return {LF && (j == 16), 16'h5A00 + 16'((j - 1) * 7)};
    endfunction

    initial begin
        logic [16:0] e1 [5];
        logic [16:0] e2 [5];
        logic [16:0] prev_data;
        logic        prev_hold;
        int          j;
        int          runs;
        int          cnt;
        int          bound;

        clk = 1'b0; rst_n = 1'b1; flush = 1'b0; start_a = 1'b0; start_b = 1'b0;
        cfg_wr_en = 1'b0; cfg_wr_blk = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_size_0 = '0; cfg_size_1 = '0;
        if_a.ready = 1'b0; if_b.ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_data_a", 32'(if_a.data), 0);
        chk("rst_valid_a", 32'(if_a.valid), 0);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_valid_b", 32'(if_b.valid), 0);
        chk("rst_done_b", 32'(done_b), 0);
        #20 rst_n = 1'b1;
        step();

        wr(1'b0, 11'd0, 16'h0011); wr(1'b0, 11'd1, 16'h0022);
        wr(1'b0, 11'd2, 16'h0033); wr(1'b0, 11'd3, 16'h0044);
        wr(1'b1, 11'd0, 16'h00A1); wr(1'b1, 11'd1, 16'h00A2);
        wr(1'b1, 11'd2, 16'h00A3);

        // Single block, ready tied high
        e1 = '{17'h00004, 17'h00011, 17'h00022, 17'h00033, {LF, 16'h0044}};
        cfg_size_0 = 12'd4;
        if_a.ready = 1'b1;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t1_valid", 32'(if_a.valid), 1);
            chk($sformatf("t1_beat%0d", i), 32'(if_a.data), 32'(e1[i]));
            step();
        end
        chk("t1_done", 32'(done_a), 1);
        chk("t1_valid_off", 32'(if_a.valid), 0);
        chk("t1_busy_off", 32'(busy_a), 0);

        // Two blocks, empty block 0
        e2 = '{{LF, 16'h0000}, 17'h00003, 17'h000A1, 17'h000A2, {LF, 16'h00A3}};
        cfg_size_0 = 12'd0; cfg_size_1 = 12'd3;
        if_b.ready = 1'b1;
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", 32'(if_b.valid), 1);
            chk($sformatf("t2_beat%0d", i), 32'(if_b.data), 32'(e2[i]));
            step();
        end
        chk("t2_done", 32'(done_b), 1);
        chk("t2_busy_off", 32'(busy_b), 0);

        // Random ready, repeated 16-word runs
        for (int i = 0; i < 16; i++) wr(1'b0, 11'(i), 16'h5A00 + 16'(i * 7));
        cfg_size_0 = 12'd16;
        if_a.ready = 1'b0;
        start_a = 1'b1; step(); start_a = 1'b0;
        j = 0; runs = 0; prev_hold = 1'b0; prev_data = '0;
        for (int c = 0; c < 1000; c++) begin
            if (prev_hold) chk("rnd_stable", 32'(if_a.data), 32'(prev_data));
            if (done_a) begin
                runs++;
                chk("rnd_run_len", 32'(j), 17);
                j = 0;
                start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            if_a.ready = 1'($urandom_range(0, 1));
            if (if_a.valid && if_a.ready) begin
                chk($sformatf("rnd_word%0d", j), 32'(if_a.data), 32'(rnd_word(j)));
                j++;
            end
            prev_hold = if_a.valid && !if_a.ready;
            prev_data = if_a.data;
            step();
        end
        chk("rnd_runs", 32'(runs >= 10), 1);
        start_a = 1'b0;
        if_a.ready = 1'b1;
        bound = 0;
        while (!done_a && bound < 100) begin step(); bound++; end
        chk("rnd_drain_done", 32'(done_a), 1);

        // Oversized length clamps to DEPTH
        cfg_size_0 = 12'd3000;
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("clamp_hdr", 32'(if_a.data), 32'h0800);
        cnt = 0; bound = 0;
        while (!done_a && bound < 3000) begin
            if (if_a.valid) cnt++;
            step();
            bound++;
        end
        chk("clamp_beats", 32'(cnt), 2049);
        chk("clamp_done", 32'(done_a), 1);

        // Flush together with an accept mid-payload
        cfg_size_0 = 12'd16;
        start_a = 1'b1; step(); start_a = 1'b0;
        step(); step();
        chk("fl_pre", 32'(if_a.data), 32'h05A07);
        flush = 1'b1; step(); flush = 1'b0;
        chk("fl_valid", 32'(if_a.valid), 0);
        chk("fl_busy", 32'(busy_a), 0);
        chk("fl_done", 32'(done_a), 0);
        if_a.ready = 1'b0;
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("fl_restart_valid", 32'(if_a.valid), 1);
        chk("fl_restart_hdr", 32'(if_a.data), 16);

        // Start and buffer writes while busy have no effect
        start_a = 1'b1;
        cfg_wr_en = 1'b1; cfg_wr_blk = 1'b0; cfg_wr_addr = 11'd0; cfg_wr_data = 16'hDEAD;
        step();
        start_a = 1'b0; cfg_wr_en = 1'b0;
        chk("bsy_hold_hdr", 32'(if_a.data), 16);
        chk("bsy_busy", 32'(busy_a), 1);
        if_a.ready = 1'b1;
        step();
        chk("bsy_buf_kept", 32'(if_a.data), 32'h05A00);
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("bsy_start_ign", 32'(if_a.data), 32'h05A07);
        step();

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(if_a.data), 0);
        chk("arst_valid", 32'(if_a.valid), 0);
        chk("arst_busy", 32'(busy_a), 0);
        chk("arst_done", 32'(done_a), 0);
        #10 rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(if_a.valid), 0);
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("post_rst_hdr", 32'(if_a.data), 16);
        step();
        chk("post_rst_word0", 32'(if_a.data), 32'h05A00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
